counter_sequencer: RTL and testbench
====================================

# counter_sequencer

Controller for the team's 4-bit counter datapath, which exposes clear, enable and direction inputs and a count output `q`. It turns operator commands (start, stop, resume, direction, one-shot/continuous) into a cycle-exact stream of single-cycle `cnt_clr` and `cnt_en` pulses plus a `cnt_up` level, and paces counting with an internal prescaler. It sits between the debounced push-button/switch logic and the counter.

## Interface
- `WIDTH`, 4: width of the controlled counter; the sequencer uses it only for `STEPS` range checks.
- `DIV`, 5: clock cycles per count step; must be at least 2.
- `STEPS`, 15: number of enable pulses in one-shot mode; range 1..2^WIDTH-1.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset is asynchronous and active-high.
- `start`  in  1: begin or restart a sequence.
- `stop`  in  1: pause.
- `resume`  in  1: continue from pause.
- `dir`  in  1: 1 = count up; sampled when `start` is accepted.
- `oneshot`  in  1: 1 = stop after `STEPS` enables; sampled when `start` is accepted.
- `cnt_clr`  out  1: counter clear pulse.
- `cnt_en`  out  1: counter step pulse.
- `cnt_up`  out  1: counter direction, registered.
- `busy`  out  1: high in CLEAR, RUN and HOLD.
- `done`  out  1: one-cycle pulse on entry to DONE.
- `state`  out  3: current FSM state, for debug.

## Operation
- FSM states: IDLE=0, CLEAR=1, RUN=2, HOLD=3, DONE=4.
- Command priority in every state: `start` > `stop` > `resume`.
- **IDLE / DONE:** `start` → CLEAR. All other inputs are ignored.
- **CLEAR:** lasts exactly one cycle with `cnt_clr`=1, then → RUN.
  - On entry: prescaler=0, step counter=0.
  - `dir` and `oneshot` are latched when `start` is accepted; `cnt_up` takes the latched `dir` on entry.
- **RUN:**
  - Prescaler counts 0..DIV-1 and wraps.
  - `cnt_en` = (state==RUN) && (prescaler==DIV-1) && !stop && !start. This is a combinational decode of registered state.
  - Each `cnt_en` increments the step counter.
  - One-shot: the `cnt_en` issued with step counter == STEPS-1 → DONE next cycle. Continuous mode never leaves RUN on its own.
  - `stop` → HOLD. `start` → CLEAR (restart).
- **HOLD:**
  - Prescaler and step counter are frozen. No `cnt_en`.
  - `resume` → RUN with the prescaler continuing from its frozen value.
  - `start` → CLEAR.
- **Simultaneous events:**
  - `stop` in the same cycle as a due tick: tick suppressed, prescaler stays at DIV-1.
  - `start` together with `stop`: restart wins.
  - `stop` outside RUN and `resume` outside HOLD are no-ops.
- **Reset (async, any time, including mid-sequence):**
  - state=IDLE, prescaler=0, steps=0, `cnt_up`=0.
  - `cnt_clr`=`cnt_en`=`busy`=`done`=0 immediately.
- **Arithmetic:** prescaler width is clog2(DIV); step counter width is WIDTH; neither ever wraps past its bound.

## Timing
- `start` sampled at edge k → CLEAR during cycle k+1, first RUN cycle is k+2.
- First `cnt_en` in cycle k+1+DIV; subsequent pulses every DIV cycles.
- One-shot: last `cnt_en` in cycle k+1+DIV·STEPS; DONE and `done`=1 in the following cycle.
- `resume` sampled at edge m with frozen prescaler p → RUN in cycle m+1; next `cnt_en` in cycle m+1+(DIV-1-p).
- Every output is valid the cycle the state is entered; there is no extra output latency.

## Structure
- Shared package `lab3_pkg` holds:
  - state enum constants IDLE/CLEAR/RUN/HOLD/DONE (3-bit);
  - default parameter constants `CNT_WIDTH`=4, `CNT_DIV`=5, `CNT_STEPS`=15.
- Sub-module `step_prescaler`: mod-DIV counter with `clr`, `hold` and `tick` ports.
- `counter_sequencer` contains the FSM, direction/mode latches and the step counter.

## Test plan
All scenarios use DIV=5 and STEPS=15 unless stated.
- One-shot up: `start` at edge 0 with `dir`=1, `oneshot`=1 → `cnt_clr` in cycle 1; 15 `cnt_en` pulses at cycles 6, 11, … 76; `done`=1 and state=4 in cycle 77; `busy`=0 from cycle 77.
- Continuous down: `start` with `dir`=0, `oneshot`=0 → `cnt_up`=0 from cycle 1; 20 `cnt_en` pulses at a 5-cycle period; state stays 2; `done` never asserts.
- Stop on tick: `stop` in cycle 11, where a tick is due → no `cnt_en` in cycle 11, state=3 in cycle 12. `resume` at edge 14 → `cnt_en` in cycle 15, then cycles 20, 25, … Total one-shot count is still 15.
- Restart from HOLD: after 7 enables, `stop`, then `start` → `cnt_clr` pulse, step counter reset, and 15 further enables before `done`.
- Simultaneous `start`+`stop` in RUN → CLEAR next cycle, not HOLD.
- Async reset mid-RUN: `rst` raised between edges → `cnt_en`, `busy` and `cnt_up` drop to 0 without a clock edge; after release, state=0 and `start` behaves exactly as in the one-shot up scenario.

Source files
------------

// File: rtl/lab3_pkg.sv
// Shared definitions for the counter sequencer: FSM state encoding and default sizing.
package lab3_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

  localparam int CNT_WIDTH = 4;
  localparam int CNT_DIV   = 5;
  localparam int CNT_STEPS = 15;

  // A 1-bit counter is still needed when DIV collapses to a single state.
  function automatic int presc_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Mod-DIV pacing counter: clr forces zero, hold freezes, tick flags the terminal count.
module step_prescaler
  import lab3_pkg::*;
#(
  parameter int DIV = CNT_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  localparam int PW = presc_width(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (!hold) begin
      count <= (count == LAST) ? '0 : count + PW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/counter_sequencer.sv
// Command FSM driving a counter's clear/enable/direction, paced by step_prescaler.
module counter_sequencer
  import lab3_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH,
  parameter int DIV   = CNT_DIV,
  parameter int STEPS = CNT_STEPS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       resume,
  input  logic       dir,
  input  logic       oneshot,
  output logic       cnt_clr,
  output logic       cnt_en,
  output logic       cnt_up,
  output logic       busy,
  output logic       done,
  output logic [2:0] state
);

  localparam logic [WIDTH-1:0] LAST_STEP = WIDTH'(STEPS - 1);

  seq_state_t       cur;
  seq_state_t       nxt;
  logic             mode_oneshot;
  logic [WIDTH-1:0] steps;
  logic             tick;
  logic             presc_hold;

  // Prescaler advances only in RUN cycles that are not being stopped or restarted,
  // so a tick suppressed by stop is still pending when RUN resumes.
  assign presc_hold = (cur != RUN) || stop;

  step_prescaler #(
    .DIV (DIV)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .clr  (start),
    .hold (presc_hold),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur <= IDLE;
    end else begin
      cur <= nxt;
    end
  end

  always_comb begin
    nxt     = cur;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    busy    = 1'b0;

    cnt_clr = (cur == CLEAR);
    cnt_en  = (cur == RUN) && tick && !stop && !start;
    busy    = (cur == CLEAR) || (cur == RUN) || (cur == HOLD);

    if (start) begin
      nxt = CLEAR;
    end else begin
      unique case (cur)
        CLEAR: nxt = RUN;
        RUN: begin
          if (stop) begin
            nxt = HOLD;
          end else if (cnt_en && mode_oneshot && (steps == LAST_STEP)) begin
            nxt = DONE;
          end
        end
        HOLD: begin
          if (resume) begin
            nxt = RUN;
          end
        end
        default: nxt = cur;
      endcase
    end
  end

  // Mode latches and step count are captured when start is accepted; the count
  // parks at its last value instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_oneshot <= 1'b0;
      cnt_up       <= 1'b0;
      steps        <= '0;
      done         <= 1'b0;
    end else begin
      done <= (nxt == DONE) && (cur != DONE);
      if (start) begin
        mode_oneshot <= oneshot;
        cnt_up       <= dir;
        steps        <= '0;
      end else if (cnt_en && mode_oneshot && (steps != LAST_STEP)) begin
        steps <= steps + WIDTH'(1);
      end
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: fixed vector table, timed scenarios and a random run against a model.
module tb_counter_sequencer;

  localparam int DIV   = 5;
  localparam int STEPS = 15;
  localparam int WIDTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, stop = 1'b0, resume = 1'b0, dir = 1'b0, oneshot = 1'b0;
  logic       cnt_clr, cnt_en, cnt_up, busy, done;
  logic [2:0] state;

  always #5 clk = ~clk;

  counter_sequencer #(.WIDTH(WIDTH), .DIV(DIV), .STEPS(STEPS)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .resume(resume),
    .dir(dir), .oneshot(oneshot), .cnt_clr(cnt_clr), .cnt_en(cnt_en),
    .cnt_up(cnt_up), .busy(busy), .done(done), .state(state)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: phase name, cycles left until the next step, steps left in the run.
  int m_state;
  int m_wait;
  int m_left;
  bit m_up, m_once, m_donep;

  int cyc;
  int en_q[$];
  int clr_q[$];
  int done_cyc;
  logic [2:0] o_state;
  logic o_clr, o_en, o_up, o_busy;

  typedef struct {
    bit s, p, r, d, o;
    int st;
    bit clr, en, up, bsy;
  } vec_t;
  vec_t tbl[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_wait = DIV - 1; m_left = STEPS;
    m_up = 0; m_once = 0; m_donep = 0;
  endtask

  task automatic model_update(input bit s, p, r, d, o, input bit en);
    m_donep = 0;
    if (s) begin
      m_state = 1; m_up = d; m_once = o; m_wait = DIV - 1; m_left = STEPS;
    end else begin
      case (m_state)
        1: m_state = 2;
        2: begin
          if (p) m_state = 3;
          else if (en) begin
            m_wait = DIV - 1;
            m_left--;
            if (m_once && m_left == 0) begin
              m_state = 4; m_donep = 1;
            end
          end else m_wait--;
        end
        3: if (r) m_state = 2;
        default: ;
      endcase
    end
  endtask

  task automatic step(input bit s, p, r, d, o);
    bit exp_en;
    start = s; stop = p; resume = r; dir = d; oneshot = o;
    @(negedge clk);
    exp_en = (m_state == 2) && (m_wait == 0) && !p && !s;
    check("state",   state,   m_state);
    check("cnt_clr", cnt_clr, m_state == 1);
    check("cnt_en",  cnt_en,  exp_en);
    check("cnt_up",  cnt_up,  m_up);
    check("busy",    busy,    (m_state >= 1) && (m_state <= 3));
    check("done",    done,    m_donep);
    o_state = state; o_clr = cnt_clr; o_en = cnt_en; o_up = cnt_up; o_busy = busy;
    if (cnt_en === 1'b1) en_q.push_back(cyc);
    if (cnt_clr === 1'b1) clr_q.push_back(cyc);
    if (done === 1'b1) done_cyc = cyc;
    @(posedge clk);
    model_update(s, p, r, d, o, exp_en);
    #1;
    cyc++;
  endtask

  task automatic idle_until(input int c);
    while (cyc < c) step(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 0; stop = 0; resume = 0; dir = 0; oneshot = 0;
    @(posedge clk);
    #1;
    model_reset();
    check("rst_state", state, 0);
    check("rst_busy", busy, 0);
    check("rst_clr", cnt_clr, 0);
    check("rst_en", cnt_en, 0);
    check("rst_up", cnt_up, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc = 0;
    en_q.delete();
    clr_q.delete();
    done_cyc = -1;
  endtask

  task automatic oneshot_up_run(input string tag);
    step(1, 0, 0, 1, 1);
    idle_until(82);
    check({tag, "_clr_cycle"}, (clr_q.size() > 0) ? clr_q[0] : -1, 1);
    check({tag, "_en_count"}, en_q.size(), STEPS);
    if (en_q.size() == STEPS) begin
      for (int i = 0; i < STEPS; i++) check({tag, "_en_cycle"}, en_q[i], 6 + DIV * i);
    end
    check({tag, "_done_cycle"}, done_cyc, 77);
  endtask

  initial begin
    tbl[0]  = '{1,0,0,0,0, 0, 0,0,0,0};
    tbl[1]  = '{0,0,0,0,0, 1, 1,0,0,1};
    tbl[2]  = '{0,0,0,0,0, 2, 0,0,0,1};
    tbl[3]  = '{0,0,0,0,0, 2, 0,0,0,1};
    tbl[4]  = '{0,0,0,0,0, 2, 0,0,0,1};
    tbl[5]  = '{0,0,0,0,0, 2, 0,0,0,1};
    tbl[6]  = '{0,0,0,0,0, 2, 0,1,0,1};
    tbl[7]  = '{1,0,0,1,1, 2, 0,0,0,1};
    tbl[8]  = '{0,0,0,0,0, 1, 1,0,1,1};
    tbl[9]  = '{0,0,0,0,0, 2, 0,0,1,1};
    tbl[10] = '{0,1,0,0,0, 2, 0,0,1,1};
    tbl[11] = '{0,0,0,0,0, 3, 0,0,1,1};
    tbl[12] = '{0,0,1,0,0, 3, 0,0,1,1};
    tbl[13] = '{0,0,0,0,0, 2, 0,0,1,1};
    tbl[14] = '{0,0,0,0,0, 2, 0,0,1,1};
    tbl[15] = '{0,0,0,0,0, 2, 0,0,1,1};
    tbl[16] = '{0,0,0,0,0, 2, 0,1,1,1};
    tbl[17] = '{1,1,0,1,1, 2, 0,0,1,1};
    tbl[18] = '{0,0,0,0,0, 1, 1,0,1,1};

    // Fixed vectors: continuous down, restart into one-shot up, stop/resume, start+stop.
    do_reset();
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].s, tbl[i].p, tbl[i].r, tbl[i].d, tbl[i].o);
      check("tbl_state", o_state, tbl[i].st);
      check("tbl_clr",   o_clr,   tbl[i].clr);
      check("tbl_en",    o_en,    tbl[i].en);
      check("tbl_up",    o_up,    tbl[i].up);
      check("tbl_busy",  o_busy,  tbl[i].bsy);
    end

    do_reset();
    oneshot_up_run("oneshot");

    // Continuous down: 20 pulses on a 5-cycle period, never done.
    do_reset();
    step(1, 0, 0, 0, 0);
    idle_until(6 + DIV * 19 + 3);
    check("cont_en_count", en_q.size(), 20);
    check("cont_last_en", (en_q.size() == 20) ? en_q[19] : -1, 6 + DIV * 19);
    check("cont_done", done_cyc, -1);

    // Stop exactly on a due tick, resume three cycles later.
    do_reset();
    step(1, 0, 0, 1, 1);
    while (cyc < 90) step(0, cyc == 11, cyc == 14, 0, 0);
    check("stoptick_en_count", en_q.size(), STEPS);
    check("stoptick_en1", (en_q.size() > 1) ? en_q[1] : -1, 15);
    check("stoptick_en2", (en_q.size() > 2) ? en_q[2] : -1, 20);
    check("stoptick_last", (en_q.size() == STEPS) ? en_q[STEPS-1] : -1, 80);
    check("stoptick_done", done_cyc, 81);

    // Restart from HOLD after seven enables.
    do_reset();
    step(1, 0, 0, 1, 1);
    idle_until(37);
    check("restart_before", en_q.size(), 7);
    step(0, 1, 0, 0, 0);
    idle_until(40);
    step(1, 0, 0, 1, 1);
    idle_until(125);
    check("restart_clr", (clr_q.size() == 2) ? clr_q[1] : -1, 41);
    check("restart_after", en_q.size() - 7, STEPS);
    check("restart_first", (en_q.size() > 7) ? en_q[7] : -1, 46);
    check("restart_done", done_cyc, 117);

    // Asynchronous reset between edges while an enable is being issued.
    do_reset();
    step(1, 0, 0, 1, 1);
    idle_until(6);
    start = 0; stop = 0; resume = 0;
    @(negedge clk);
    check("async_pre_en", cnt_en, 1);
    #2 rst = 1'b1;
    #1;
    check("async_en", cnt_en, 0);
    check("async_busy", busy, 0);
    check("async_up", cnt_up, 0);
    check("async_state", state, 0);
    do_reset();
    oneshot_up_run("after_async");

    // Random commands against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 119) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
